// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and divisor helpers used by both line ends.
package uart_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_IDX_W = 3;
  localparam int unsigned SYNC_STG  = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_WAIT_HI = 3'd4
  } rx_state_e;

  // Integer-floor divisor so emitter and receiver agree on the bit period.
  function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic int unsigned uart_half(input int unsigned div);
    return div / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the async rx pin; resets to the idle-high line level.
module uart_rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  if (STAGES < 2) begin : g_bad_stages
    $error("uart_rx_sync: STAGES must be >= 2");
  end

  always_ff @(posedge clk) begin
    if (!resetn) ff <= '1;
    else         ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: centre-samples each bit from the synchronised line and holds one byte
// for the CPU, flagging framing errors (pulse) and dropped bytes (sticky overrun).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 27_000_000,
  parameter int unsigned BAUD_RATE   = 115_200
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned DIV   = uart_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned HALF  = uart_half(DIV);
  localparam int unsigned CNT_W = $clog2(DIV);

  if (DIV < 4) begin : g_bad_div
    $error("uart_receiver: CLK_FREQ_HZ/BAUD_RATE must be >= 4");
  end

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV - 1);

  logic                 rx_s;
  rx_state_e            state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [BYTE_W-1:0]    shreg;
  logic                 sample;

  uart_rx_sync #(
    .STAGES (SYNC_STG)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (rx),
    .q      (rx_s)
  );

  assign sample = (cnt == '0);

  // Receive FSM, bit timer and output holding register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      if (rx_ack) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            cnt   <= CNT_HALF;
            busy  <= 1'b1;
          end
        end

        ST_START: begin
          if (!sample) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!rx_s) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            cnt     <= CNT_DIV;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        ST_DATA: begin
          if (!sample) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shreg   <= {rx_s, shreg[BYTE_W-1:1]};
            bit_idx <= bit_idx + BIT_IDX_W'(1);
            cnt     <= CNT_DIV;
            if (bit_idx == BIT_IDX_W'(BYTE_W - 1)) state <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (!sample) begin
            cnt <= cnt - CNT_W'(1);
          end else if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            // An ack in the same cycle frees the holder, so the new byte wins.
            if (!rx_valid || rx_ack) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            state     <= ST_WAIT_HI;
            frame_err <= 1'b1;
          end
        end

        ST_WAIT_HI: begin
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed + randomised bench for uart_receiver against a byte-level holding-register model.
module tb_uart_receiver;

  localparam int DIV     = 27_000_000 / 115_200;
  localparam int HALF    = DIV / 2;
  localparam int DELIVER = HALF + 9 * DIV + 3;  // drive edge to rx_valid, counted in clk edges

  logic       clk;
  logic       resetn;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  int         cyc = 0;
  int         fe_cnt = 0;
  int         valid_rises = 0;
  int         rise_cyc = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] got[$];

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovr;

  uart_receiver dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log of outputs, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (rx_valid && !prev_valid) begin
      rise_cyc    <= cyc;
      valid_rises <= valid_rises + 1;
    end
    if (rx_valid && (!prev_valid || rx_data != prev_data)) got.push_back(rx_data);
    prev_valid <= rx_valid;
    prev_data  <= rx_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_ack();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good, input bit ack_same);
    if (good) begin
      if (ack_same) m_ovr = 1'b0;
      if (!m_valid || ack_same) begin
        m_data  = b;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endtask

  task automatic check_state(input string tag, input logic exp_busy);
    chk({tag, ".data"},    32'(rx_data),  32'(m_data));
    chk({tag, ".valid"},   32'(rx_valid), 32'(m_valid));
    chk({tag, ".overrun"}, 32'(overrun),  32'(m_ovr));
    chk({tag, ".busy"},    32'(busy),     32'(exp_busy));
  endtask

  // Called #1 after a posedge; optional rx_ack pulse sampled at clk edge ack_edge of the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_edge);
    logic [9:0] bits;
    int n;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int k = 0; k < DIV; k++) begin
        n = i * DIV + k + 1;
        rx_ack = (n == ack_edge);
        @(posedge clk); #1;
      end
    end
    rx_ack = 1'b0;
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(posedge clk); #1;
    rx_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int start;
    int fe0;
    int vr0;
    int idle_at;
    logic [7:0] b;
    bit coincide;

    resetn = 1'b0;
    rx     = 1'b0;
    rx_ack = 1'b0;
    model_reset();

    // Reset with the line held low
    idle(5);
    chk("reset.data",      32'(rx_data),   32'h00);
    chk("reset.valid",     32'(rx_valid),  32'h0);
    chk("reset.frame_err", 32'(frame_err), 32'h0);
    chk("reset.overrun",   32'(overrun),   32'h0);
    chk("reset.busy",      32'(busy),      32'h0);
    rx     = 1'b1;
    resetn = 1'b1;
    idle(3000);
    chk("post_reset.rises", 32'(valid_rises), 32'h0);
    chk("post_reset.fe",    32'(fe_cnt),      32'h0);
    check_state("post_reset", 1'b0);

    // Single frame latency
    start = cyc;
    send_frame(8'h55, 1'b1, 0);
    model_frame(8'h55, 1'b1, 1'b0);
    chk("latency", 32'(rise_cyc - start), 32'(DELIVER));
    check_state("frame55", 1'b0);
    do_ack();
    model_ack();
    check_state("ack55", 1'b0);
    idle(20);

    // Back-to-back frames, first acked before the second lands
    got.delete();
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1, DELIVER + 60);
    send_frame(8'h3C, 1'b1, 0);
    model_frame(8'hA5, 1'b1, 1'b0);
    model_ack();
    model_frame(8'h3C, 1'b1, 1'b0);
    chk("b2b.count", 32'(got.size()), 32'd2);
    if (got.size() >= 2) begin
      chk("b2b.byte0", 32'(got[0]), 32'hA5);
      chk("b2b.byte1", 32'(got[1]), 32'h3C);
    end
    chk("b2b.fe", 32'(fe_cnt - fe0), 32'h0);
    check_state("b2b", 1'b0);
    do_ack();
    model_ack();
    idle(20);

    // Start-bit glitch
    fe0   = fe_cnt;
    vr0   = valid_rises;
    start = cyc;
    rx    = 1'b0;
    idle(50);
    chk("glitch.busy_hi", 32'(busy), 32'h1);
    rx = 1'b1;
    idle_at = -1;
    while (cyc - start < 400) begin
      @(posedge clk); #1;
      if (!busy) begin
        idle_at = cyc - start;
        break;
      end
    end
    chk("glitch.idle_at", 32'(idle_at), 32'(HALF + 3));
    chk("glitch.fe",      32'(fe_cnt - fe0),      32'h0);
    chk("glitch.rises",   32'(valid_rises - vr0), 32'h0);
    idle(20);

    // Framing error followed by a held-low break
    fe0 = fe_cnt;
    send_frame(8'hF0, 1'b0, 0);
    model_frame(8'hF0, 1'b0, 1'b0);
    idle(5 * DIV);
    chk("frame.fe_once", 32'(fe_cnt - fe0), 32'h1);
    check_state("frame.held", 1'b1);
    rx = 1'b1;
    idle(4);
    check_state("frame.released", 1'b0);
    idle(20);

    // Overrun, then ack/deliver collision
    send_frame(8'h11, 1'b1, 0);
    model_frame(8'h11, 1'b1, 1'b0);
    idle(10);
    send_frame(8'h22, 1'b1, 0);
    model_frame(8'h22, 1'b1, 1'b0);
    check_state("overrun", 1'b0);
    do_ack();
    model_ack();
    check_state("overrun.ack", 1'b0);
    idle(10);
    send_frame(8'h33, 1'b1, 0);
    model_frame(8'h33, 1'b1, 1'b0);
    idle(10);
    send_frame(8'h44, 1'b1, DELIVER);
    model_frame(8'h44, 1'b1, 1'b1);
    check_state("collision", 1'b0);
    do_ack();
    model_ack();
    idle(10);

    // Random bytes with random ack behaviour
    for (int i = 0; i < 8; i++) begin
      b        = 8'($urandom);
      coincide = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        model_ack();
      end
      send_frame(b, 1'b1, coincide ? DELIVER : 0);
      model_frame(b, 1'b1, coincide);
      idle(int'($urandom_range(0, 50)));
      check_state($sformatf("rand%0d", i), 1'b0);
    end

    // Reset in the middle of DATA
    vr0 = valid_rises;
    rx  = 1'b0;
    idle(3 * DIV);
    resetn = 1'b0;
    idle(1);
    resetn = 1'b1;
    rx     = 1'b1;
    model_reset();
    idle(3000);
    chk("midreset.rises", 32'(valid_rises - vr0), 32'h0);
    check_state("midreset", 1'b0);
    b = 8'($urandom);
    send_frame(b, 1'b1, 0);
    model_frame(b, 1'b1, 1'b0);
    check_state("midreset.next", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
